// File: rtl/sym2_serializer.sv
// sym2_serializer: turns bytes into 2-bit symbols, MSB pair first.
// When CHECK_EN is set, each frame ends with an XOR check symbol.
// A one-entry pending buffer lets the next byte load at frame end,
// so frames stream back to back without an idle cycle.
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no frame in flight, waiting for the pending buffer
// S_DATA  | presenting data symbols sym_idx 0..3
// S_CHECK | presenting the XOR check symbol
module sym2_serializer #(
    parameter bit CHECK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       sym_valid,
    input  logic       sym_ready,
    output logic [1:0] sym_data,
    output logic       sym_last,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic       r_pend_full;
    logic [7:0] r_pend_data;
    logic       r_in_ready;
    logic [7:0] r_shift;
    logic [1:0] r_sym_idx;
    logic [1:0] r_acc;

    logic       w_accept;
    logic       w_sym_fire;
    logic       w_frame_end;
    logic       w_load;
    logic       w_pend_full_nxt;

    assign w_accept   = in_valid && r_in_ready;
    assign w_sym_fire = sym_valid && sym_ready;
    assign in_ready   = r_in_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; a frame end chains straight into the pending byte.
    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_full) begin
                    w_state_nxt = S_DATA;
                    w_load      = 1'b1;
                end
            end
            S_DATA: begin
                if (w_sym_fire && (r_sym_idx == 2'd3)) begin
                    if (CHECK_EN) begin
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_frame_end = 1'b1;
                    end
                end
            end
            S_CHECK: begin
                if (w_sym_fire) begin
                    w_frame_end = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_frame_end) begin
            if (r_pend_full) begin
                w_state_nxt = S_DATA;
                w_load      = 1'b1;
            end else begin
                w_state_nxt = S_IDLE;
            end
        end
    end

    // Output decode from registered state only, so outputs hold while stalled.
    always_comb begin
        sym_valid = 1'b0;
        sym_data  = 2'd0;
        sym_last  = 1'b0;
        case (r_state)
            S_DATA: begin
                sym_valid = 1'b1;
                sym_data  = r_shift[7:6];
                sym_last  = !CHECK_EN && (r_sym_idx == 2'd3);
            end
            S_CHECK: begin
                sym_valid = 1'b1;
                sym_data  = r_acc;
                sym_last  = 1'b1;
            end
            default: begin
                sym_valid = 1'b0;
            end
        endcase
        busy = r_pend_full || (r_state != S_IDLE);
    end

    // Pending buffer occupancy; accept and drain can never coincide
    // because in_ready is low whenever the buffer is full.
    always_comb begin
        w_pend_full_nxt = r_pend_full;
        if (w_accept) begin
            w_pend_full_nxt = 1'b1;
        end else if (w_load) begin
            w_pend_full_nxt = 1'b0;
        end
    end

    // Pending buffer and registered in_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend_full <= 1'b0;
            r_pend_data <= 8'd0;
            r_in_ready  <= 1'b0;
        end else begin
            r_pend_full <= w_pend_full_nxt;
            r_in_ready  <= !w_pend_full_nxt;
            if (w_accept) begin
                r_pend_data <= in_data;
            end
        end
    end

    // Frame datapath: shift register, symbol index and check accumulator.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift   <= 8'd0;
            r_sym_idx <= 2'd0;
            r_acc     <= 2'd0;
        end else if (w_load) begin
            r_shift   <= r_pend_data;
            r_sym_idx <= 2'd0;
            r_acc     <= 2'd0;
        end else if ((r_state == S_DATA) && w_sym_fire) begin
            r_shift   <= {r_shift[5:0], 2'b00};
            r_acc     <= r_acc ^ r_shift[7:6];
            r_sym_idx <= r_sym_idx + 2'd1;
        end
    end

endmodule
